ifu_fetch: RTL

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit. Owns the PC and issues one instruction-memory
// request at a time. It holds the returned word for the decoder until the core
// advances, then computes the next PC from npc_op.
//
// Optional feature, selected by the macro IFU_ALIGN_CHECK_EN:
//   defined   - a misaligned next-PC raises a sticky fault and parks the unit in HALT
//   undefined - next-PC[1:0] is forced to 00, fault is tied low, HALT is unreachable
module ifu_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  npc_op,
  input  logic [25:0] imm,
  input  logic [31:0] ra,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  localparam logic [31:0] ResetPc = 32'h0000_3000;

  typedef enum logic [1:0] {StBoot, StFetch, StValid, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_raw;
  logic [31:0] npc;
  logic        misaligned;
  logic        adv_accept;

  assign pc_plus4    = pc_q + 32'd4;
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == StValid);
  assign imem_req    = (state_q == StFetch);
  assign adv_accept  = (state_q == StValid) && advance;

  // Next-PC candidate; all sums wrap modulo 2^32.
  always_comb begin
    npc_raw = pc_plus4;
    case (npc_op)
      2'b00:   npc_raw = pc_plus4;
      2'b01:   npc_raw = pc_plus4 + {{14{imm[15]}}, imm[15:0], 2'b00};
      2'b10:   npc_raw = {pc_plus4[31:28], imm, 2'b00};
      default: npc_raw = ra;
    endcase
  end

`ifdef IFU_ALIGN_CHECK_EN
  assign npc        = npc_raw;
  assign misaligned = |npc_raw[1:0];

  logic fault_q;

  // Sticky fault, only cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (adv_accept && misaligned) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  // Low bits dropped so jump-register targets are always word aligned.
  assign npc        = npc_raw & ~32'd3;
  assign misaligned = 1'b0;
  assign fault      = 1'b0;
`endif

  // Next-state, PC and instruction-holding logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      StBoot: begin
        state_d = StFetch;
      end
      StFetch: begin
        // Acks outside this state are ignored.
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StValid;
        end
      end
      StValid: begin
        if (adv_accept) begin
          if (misaligned) begin
            state_d = StHalt;
          end else begin
            pc_d    = npc;
            state_d = StFetch;
          end
        end
      end
      default: begin
        state_d = StHalt;
      end
    endcase
  end

  // State registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= ResetPc;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

endmodule
